// File: rtl/stack_arbiter.sv
// Round-robin arbiter that shares one LIFO stack among NUM_REQ requesters.
// One stack operation is in flight at a time, and every output is registered.
module stack_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_push,
    input  logic [NUM_REQ-1:0]            req_pop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          busy,
    output logic                          stk_push,
    output logic                          stk_pop,
    output logic [DATA_WIDTH-1:0]         stk_data_in,
    input  logic [DATA_WIDTH-1:0]         stk_data_out,
    input  logic                          stk_full,
    input  logic                          stk_empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_POP,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ID_W-1:0]         r_last_grant, w_next_last_grant;
    logic [ID_W-1:0]         r_id,         w_next_id;
    logic                    r_is_push,    w_next_is_push;
    logic [DATA_WIDTH-1:0]   r_data,       w_next_data;
    logic                    r_err,        w_next_err;

    logic [NUM_REQ-1:0]      r_req_ack,     w_next_req_ack;
    logic                    r_rsp_err,     w_next_rsp_err;
    logic [DATA_WIDTH-1:0]   r_rsp_data,    w_next_rsp_data;
    logic [ID_W-1:0]         r_rsp_id,      w_next_rsp_id;
    logic                    r_busy;
    logic                    r_stk_push,    w_next_stk_push;
    logic                    r_stk_pop,     w_next_stk_pop;
    logic [DATA_WIDTH-1:0]   r_stk_data_in, w_next_stk_data_in;

    // The requester whose ack is on the bus this cycle only drops its request
    // on the next edge, so it is masked out of that IDLE arbitration.
    logic [NUM_REQ-1:0]      w_req;
    logic                    w_found_above, w_found_any;
    logic [ID_W-1:0]         w_id_above,    w_id_any;
    logic                    w_grant_valid;
    logic [ID_W-1:0]         w_grant_id;
    logic                    w_grant_push;
    logic [DATA_WIDTH-1:0]   w_grant_data;

    assign w_req = (req_push | req_pop) & ~r_req_ack;

    // Round robin: lowest requesting index above last_grant, else lowest overall.
    always_comb begin
        w_found_above = 1'b0;
        w_found_any   = 1'b0;
        w_id_above    = '0;
        w_id_any      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_found_any = 1'b1;
                w_id_any    = ID_W'(i);
                if (ID_W'(i) > r_last_grant) begin
                    w_found_above = 1'b1;
                    w_id_above    = ID_W'(i);
                end
            end
        end
        w_grant_valid = w_found_any;
        w_grant_id    = w_found_above ? w_id_above : w_id_any;
    end

    always_comb begin
        w_grant_push = 1'b0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_grant_push = req_push[i];
                w_grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state       = r_state;
        w_next_last_grant  = r_last_grant;
        w_next_id          = r_id;
        w_next_is_push     = r_is_push;
        w_next_data        = r_data;
        w_next_err         = r_err;
        w_next_req_ack     = '0;
        w_next_rsp_err     = r_rsp_err;
        w_next_rsp_data    = r_rsp_data;
        w_next_rsp_id      = r_rsp_id;
        w_next_stk_push    = 1'b0;
        w_next_stk_pop     = 1'b0;
        w_next_stk_data_in = r_stk_data_in;

        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_next_id      = w_grant_id;
                    w_next_is_push = w_grant_push;
                    w_next_data    = w_grant_data;
                    w_next_state   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_is_push && !stk_full) begin
                    w_next_stk_push    = 1'b1;
                    w_next_stk_data_in = r_data;
                    w_next_err         = 1'b0;
                    w_next_state       = S_RESP;
                end else if (!r_is_push && !stk_empty) begin
                    w_next_stk_pop = 1'b1;
                    w_next_state   = S_WAIT_POP;
                end else begin
                    w_next_err   = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_WAIT_POP: begin
                w_next_err   = 1'b0;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_next_req_ack[i] = (r_id == ID_W'(i));
                end
                w_next_rsp_id  = r_id;
                w_next_rsp_err = r_err;
                // The stack's registered read data is valid during this state.
                if (!r_is_push && !r_err) begin
                    w_next_rsp_data = stk_data_out;
                end
                w_next_last_grant = r_id;
                w_next_state      = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_id          <= '0;
            r_is_push     <= 1'b0;
            r_data        <= '0;
            r_err         <= 1'b0;
            r_req_ack     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_id      <= '0;
            r_busy        <= 1'b0;
            r_stk_push    <= 1'b0;
            r_stk_pop     <= 1'b0;
            r_stk_data_in <= '0;
        end else begin
            r_last_grant  <= w_next_last_grant;
            r_id          <= w_next_id;
            r_is_push     <= w_next_is_push;
            r_data        <= w_next_data;
            r_err         <= w_next_err;
            r_req_ack     <= w_next_req_ack;
            r_rsp_err     <= w_next_rsp_err;
            r_rsp_data    <= w_next_rsp_data;
            r_rsp_id      <= w_next_rsp_id;
            r_busy        <= (w_next_state != S_IDLE);
            r_stk_push    <= w_next_stk_push;
            r_stk_pop     <= w_next_stk_pop;
            r_stk_data_in <= w_next_stk_data_in;
        end
    end

    assign req_ack     = r_req_ack;
    assign rsp_err     = r_rsp_err;
    assign rsp_data    = r_rsp_data;
    assign rsp_id      = r_rsp_id;
    assign busy        = r_busy;
    assign stk_push    = r_stk_push;
    assign stk_pop     = r_stk_pop;
    assign stk_data_in = r_stk_data_in;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: a 4-deep behavioural stack plus a
// scoreboard of expected acks, compared whenever the DUT pulses req_ack.
module tb_stack_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ID_W       = 3;
    localparam int DEPTH      = 4;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_push;
    logic [NUM_REQ-1:0]            req_pop;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          rsp_err;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]               rsp_id;
    logic                          busy;
    logic                          stk_push;
    logic                          stk_pop;
    logic [DATA_WIDTH-1:0]         stk_data_in;
    logic [DATA_WIDTH-1:0]         stk_data_out;
    logic                          stk_full;
    logic                          stk_empty;

    stack_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
        .req_ack(req_ack), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural stack: registered read data, reset by the same rst.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [2:0]            cnt;

    always @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            stk_data_out <= '0;
        end else if (stk_push && cnt < 3'(DEPTH)) begin
            mem[cnt] <= stk_data_in;
            cnt      <= cnt + 3'd1;
        end else if (stk_pop && cnt != 3'd0) begin
            stk_data_out <= mem[cnt - 3'd1];
            cnt          <= cnt - 3'd1;
        end
    end

    assign stk_full  = (cnt == 3'(DEPTH));
    assign stk_empty = (cnt == 3'd0);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic                  err;
        logic                  is_pop;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    exp_t               sb[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 n_push = 0;
    int                 n_pop  = 0;
    logic [NUM_REQ-1:0] hold   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1ns after the edge, score any ack, release acked requests.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (stk_push || stk_pop) begin
            check("strobe_exclusive", 32'(stk_push & stk_pop), 32'd0);
        end
        n_push += int'(stk_push);
        n_pop  += int'(stk_pop);
        if (req_ack != '0) begin
            check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(req_ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_bit", 32'(req_ack), 32'd1 << e.id);
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.is_pop && !e.err) begin
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] && !hold[i]) begin
                    req_push[i] = 1'b0;
                    req_pop[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input int id, input logic push, input logic pop,
                         input logic [DATA_WIDTH-1:0] d, input logic err,
                         input logic [DATA_WIDTH-1:0] exp_data);
        exp_t e;
        req_push[id] = push;
        req_pop[id]  = pop;
        req_data[id*DATA_WIDTH +: DATA_WIDTH] = d;
        e.id     = ID_W'(id);
        e.err    = err;
        e.is_pop = !push;
        e.data   = exp_data;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int np;

    initial begin
        rst      = 1'b1;
        req_push = '0;
        req_pop  = '0;
        req_data = '0;
        step();
        step();
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stk_push", 32'(stk_push), 32'd0);
        check("rst_stk_pop", 32'(stk_pop), 32'd0);
        check("rst_stk_data_in", 32'(stk_data_in), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        step();

        // Push 0xA5 by requester 0: strobe in cycle 2, ack in cycle 3.
        issue(0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
        step();
        check("push_c1_busy", 32'(busy), 32'd1);
        check("push_c1_no_strobe", 32'(stk_push), 32'd0);
        step();
        check("push_c2_strobe", 32'(stk_push), 32'd1);
        check("push_c2_data_in", 32'(stk_data_in), 32'hA5);
        check("push_c2_no_ack", 32'(req_ack), 32'd0);
        step();
        check("push_c3_acked", 32'(sb.size()), 32'd0);
        step();
        check("push_strobe_once", 32'(stk_push), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Pop by requester 2: strobe in cycle 2, ack with 0xA5 in cycle 4.
        issue(2, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA5);
        step();
        check("pop_c1_no_strobe", 32'(stk_pop), 32'd0);
        step();
        check("pop_c2_strobe", 32'(stk_pop), 32'd1);
        step();
        check("pop_c3_pending", 32'(sb.size()), 32'd1);
        step();
        check("pop_c4_acked", 32'(sb.size()), 32'd0);
        step();

        // Pop on empty stack: rejected, no strobe.
        np = n_pop;
        issue(1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        drain(10);
        check("empty_pop_no_strobe", 32'(n_pop), 32'(np));

        // Fill, then a push is rejected without a strobe.
        for (int k = 0; k < DEPTH; k++) begin
            issue(1, 1'b1, 1'b0, 8'(k + 1), 1'b0, 8'h00);
            drain(10);
        end
        np = n_push;
        issue(2, 1'b1, 1'b0, 8'hEE, 1'b1, 8'h00);
        drain(10);
        check("full_push_no_strobe", 32'(n_push), 32'(np));
        for (int k = 0; k < DEPTH; k++) begin
            issue(3, 1'b0, 1'b1, 8'h00, 1'b0, 8'(DEPTH - k));
            drain(10);
        end

        // Push and pop asserted together: push wins.
        np = n_push;
        issue(1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
        drain(10);
        check("push_wins_strobe", 32'(n_push), 32'(np + 1));
        issue(1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h77);
        drain(10);

        // After reset, four simultaneous pushes are granted 0,1,2,3.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            issue(i, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 8'h00);
        end
        drain(40);
        for (int i = 0; i < NUM_REQ; i++) begin
            issue(i, 1'b0, 1'b1, 8'h00, 1'b0, 8'(8'h13 - i));
        end
        drain(40);

        // Requesters 0 and 3 held continuously alternate 0,3,0,3.
        hold = 4'b1001;
        issue(0, 1'b1, 1'b0, 8'hC0, 1'b0, 8'h00);
        issue(3, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h00);
        issue(0, 1'b1, 1'b0, 8'hC0, 1'b0, 8'h00);
        issue(3, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h00);
        drain(40);
        hold     = '0;
        req_push = '0;
        step();
        step();
        check("fair_no_extra_grant", 32'(busy), 32'd0);

        // Reset during WAIT_POP drops the op; the next request is served.
        apply_reset();
        issue(0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00);
        drain(10);
        req_pop[2] = 1'b1;
        step();
        step();
        check("wp_strobe", 32'(stk_pop), 32'd1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        req_pop[2] = 1'b0;
        check("wp_rst_busy", 32'(busy), 32'd0);
        check("wp_rst_no_ack", 32'(req_ack), 32'd0);
        check("wp_rst_no_pop", 32'(stk_pop), 32'd0);
        check("wp_rst_rsp_data", 32'(rsp_data), 32'd0);
        step();
        check("wp_after_busy", 32'(busy), 32'd0);
        issue(3, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00);
        drain(10);
        issue(3, 1'b0, 1'b1, 8'h00, 1'b0, 8'h3C);
        drain(10);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
